// File: rtl/dap_bit_shifter.sv
// dap_bit_shifter: LSB-first serial shift engine paced by the baud generator's
// drive (sclk_negedge) and sample (sclk_sampling) strobes.
module dap_bit_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  sclk_negedge,
    input  logic                  sclk_sampling,
    output logic                  gen_sampling,
    input  logic                  din,
    output logic                  dout,
    output logic                  dout_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, ARM, SHIFT, FINISH} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [LEN_WIDTH-1:0] n_q, tx_cnt, rx_cnt, rx_cnt_nx, eff_len;
    logic drv_q, accept, arm_go, samp_ok, drv_ok, fin_go;
    assign eff_len = (len == '0 || len > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : len;
    assign gen_sampling = state == SHIFT;
    assign done = state == FINISH;
    // The sample is resolved before the drive strobe, so a coincident final sample can end the transfer.
    always_comb begin
        accept = state == IDLE && start;
        arm_go = state == ARM && sclk_negedge;
        samp_ok = state == SHIFT && sclk_sampling && rx_cnt < n_q;
        rx_cnt_nx = samp_ok ? rx_cnt + LEN_WIDTH'(1) : rx_cnt;
        drv_ok = state == SHIFT && sclk_negedge && tx_cnt < n_q;
        fin_go = state == SHIFT && sclk_negedge && tx_cnt == n_q && rx_cnt_nx == n_q;
        state_nx = accept ? ARM : arm_go ? SHIFT : fin_go ? FINISH : state == FINISH ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q <= '0;
            drv_q <= 1'b0;
            n_q <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            dout <= 1'b1;
            dout_oe <= 1'b0;
            rx_data <= '0;
            busy <= 1'b0;
        end else begin
            if (accept) begin
                tx_q <= tx_data;
                drv_q <= drive_en;
                n_q <= eff_len;
                rx_data <= '0;
                busy <= 1'b1;
            end
            if (arm_go) begin
                dout <= tx_q[0];
                tx_q <= tx_q >> 1;
                dout_oe <= drv_q;
                tx_cnt <= LEN_WIDTH'(1);
                rx_cnt <= '0;
            end
            if (samp_ok) begin
                rx_data[rx_cnt[IW-1:0]] <= din;
                rx_cnt <= rx_cnt_nx;
            end
            if (drv_ok) begin
                dout <= tx_q[0];
                tx_q <= tx_q >> 1;
                tx_cnt <= tx_cnt + LEN_WIDTH'(1);
            end
            if (state == FINISH) begin
                busy <= 1'b0;
                dout_oe <= 1'b0;
                dout <= 1'b1;
            end
        end
    end
endmodule

// File: doc/dap_bit_shifter.md
Name: dap_bit_shifter

Overview:
- Serial bit engine directly downstream of the DAP baud generator.
- Consumes the generator's per-bit strobes: sclk_negedge marks the drive instant and sclk_sampling marks the sample instant.
- Shifts a parallel word out on a data pin, LSB first, and captures the pin into a parallel word on the sample strobe.
- The SWD/JTAG sequencers above it issue one transfer of 1..DATA_WIDTH bits per start and wait for done.

Parameters:
- DATA_WIDTH, 32, maximum bits per transfer; width of tx_data/rx_data.
- LEN_WIDTH, 6, width of len; must satisfy 2^LEN_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock; baud strobes are synchronous to it.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- len  input  LEN_WIDTH  bit count; 0 or any value > DATA_WIDTH means DATA_WIDTH.
- drive_en  input  1  1 = write transfer (pin driven); 0 = read-only (pin released).
- tx_data  input  DATA_WIDTH  data to shift out, bit 0 first.
- sclk_negedge  input  1  drive strobe from the baud generator.
- sclk_sampling  input  1  sample strobe from the baud generator.
- gen_sampling  output  1  sample-request enable to the baud generator; high in SHIFT.
- din  input  1  pin input, already synchronised.
- dout  output  1  pin output value.
- dout_oe  output  1  pin output enable.
- rx_data  output  DATA_WIDTH  captured bits, bit i = i-th sampled bit; upper bits 0.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at transfer end.

Behaviour:
- Reset values: dout=1, dout_oe=0, rx_data=0, busy=0, done=0, gen_sampling=0, state=IDLE, counters 0.
- States: IDLE, ARM, SHIFT, FINISH.
- IDLE:
  - start=1 latches tx_data, drive_en and the effective length (N, 1..DATA_WIDTH).
  - Same start: clears rx_data, sets busy=1 next cycle, goes to ARM.
  - start while busy=1 is ignored; no queueing.
- ARM: waits for sclk_negedge. On it:
  - dout <= tx bit 0 and dout_oe <= drive_en (registered, visible the next cycle).
  - tx_cnt <= 1, rx_cnt <= 0, go to SHIFT.
  - sclk_sampling in ARM is ignored.
- SHIFT, gen_sampling=1:
  - On sclk_sampling with rx_cnt < N: rx_data[rx_cnt] <= din, rx_cnt++.
  - On sclk_negedge with tx_cnt < N: dout <= tx bit tx_cnt, tx_cnt++.
  - On sclk_negedge with tx_cnt == N and rx_cnt == N: go to FINISH. dout holds the last bit; dout_oe is unchanged.
  - If both strobes occur in the same cycle, the sample is taken first. When this sample completes rx_cnt == N and tx_cnt == N, the same negedge transitions to FINISH.
  - Extra sclk_sampling strobes with rx_cnt == N are ignored.
- FINISH (1 cycle):
  - done=1, busy <= 0, dout_oe <= 0, dout <= 1, go to IDLE.
  - rx_data holds its value until the next accepted start.
- Timing: a transfer of N bits takes N+1 sclk_negedge strobes after ARM entry (the first drives bit 0, the last ends the transfer), plus one clk for FINISH.
- Counters are LEN_WIDTH wide and never wrap: compare-then-increment, saturated at N.
- Read-only transfer (drive_en=0): dout_oe stays 0 for the whole transfer; dout still follows tx bits; rx capture is identical.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously); no done pulse is generated.

Test Plan:
- Write 8 bits: len=8, drive_en=1, tx_data=0xA5, din looped from dout.
  - Required: dout sequence 1,0,1,0,0,1,0,1 after successive negedges; rx_data=0x000000A5; one done pulse after the 9th negedge; dout_oe falls with done.
- Read 32 bits: len=0, drive_en=0, din driven 0xDEADBEEF LSB first on each sample.
  - Required: rx_data=0xDEADBEEF; dout_oe=0 throughout; busy high for exactly 33 negedges + 1 clk.
- Coincident strobes: sclk_sampling and sclk_negedge asserted in the same cycle on every bit, len=3, din=1.
  - Required: rx_data=0x7; done after the 4th negedge; no bit lost or duplicated.
- Start while busy: second start with tx_data=0xFF mid-transfer of len=4, tx=0x3.
  - Required: ignored; dout sequence 1,1,0,0; single done.
- Reset mid-operation: assert reset after 5 of 16 bits.
  - Required: immediately dout=1, dout_oe=0, busy=0, rx_data=0, no done.
  - After release, a fresh len=1 transfer completes normally.
- Length 1 boundary: len=1, tx=1, din=0.
  - Required: dout=1 for one bit period; rx_data=0; done after the 2nd negedge.
